// File: rtl/vga_draw_arbiter.sv
// Shares the VGA adapter's single pixel-write port between NUM_REQ drawer units,
// with round-robin ownership, a one-cycle plot-free gap between owners and a full-screen clear engine.
module vga_draw_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
  parameter int unsigned X_MAX        = 159,
  parameter int unsigned Y_MAX        = 119
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ-1:0]     i_release,
  input  logic [8*NUM_REQ-1:0]   i_req_x,
  input  logic [7*NUM_REQ-1:0]   i_req_y,
  input  logic [3*NUM_REQ-1:0]   i_req_colour,
  input  logic [NUM_REQ-1:0]     i_req_plot,
  input  logic                   i_clear_req,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_clear_busy,
  output logic [7:0]             o_vga_x,
  output logic [6:0]             o_vga_y,
  output logic [2:0]             o_vga_colour,
  output logic                   o_vga_plot
);

  localparam int unsigned       IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]        X_LAST     = 8'(X_MAX);
  localparam logic [6:0]        Y_LAST     = 7'(Y_MAX);
  localparam logic [IDX_W-1:0]  OWNER_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]    NUM_REQ_W  = (IDX_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_CLEAR, S_GAP} state_e;

  state_e               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_rr;
  logic                 r_clear_pending;
  logic                 r_clear_busy;
  logic [7:0]           r_cx;
  logic [6:0]           r_cy;
  logic [7:0]           r_vga_x;
  logic [6:0]           r_vga_y;
  logic [2:0]           r_vga_colour;
  logic                 r_vga_plot;

  logic                 w_any_req;
  logic [IDX_W-1:0]     w_winner;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_pos;
  logic [7:0]           w_own_x;
  logic [6:0]           w_own_y;
  logic [2:0]           w_own_colour;
  logic                 w_own_plot;
  logic                 w_own_req;
  logic                 w_own_rel;

  assign w_any_req = |i_req;

  // Walk downwards so the requester closest to r_rr (in wrap order) is written last and wins.
  always_comb begin
    w_winner = r_rr;
    w_sum    = '0;
    w_pos    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr} + (IDX_W + 1)'(i);
      if (w_sum >= NUM_REQ_W) w_sum = w_sum - NUM_REQ_W;
      w_pos = w_sum[IDX_W-1:0];
      if (i_req[w_pos]) w_winner = w_pos;
    end
  end

  always_comb begin
    w_own_x      = '0;
    w_own_y      = '0;
    w_own_colour = '0;
    w_own_plot   = 1'b0;
    w_own_req    = 1'b0;
    w_own_rel    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IDX_W'(i)) begin
        w_own_x      = i_req_x[8*i +: 8];
        w_own_y      = i_req_y[7*i +: 7];
        w_own_colour = i_req_colour[3*i +: 3];
        w_own_plot   = i_req_plot[i];
        w_own_req    = i_req[i];
        w_own_rel    = i_release[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_owner         <= '0;
      r_rr            <= '0;
      r_clear_pending <= 1'b0;
      r_clear_busy    <= 1'b0;
      r_cx            <= '0;
      r_cy            <= '0;
      r_vga_x         <= '0;
      r_vga_y         <= '0;
      r_vga_colour    <= '0;
      r_vga_plot      <= 1'b0;
    end else begin
      if (i_clear_req && (r_state != S_CLEAR)) r_clear_pending <= 1'b1;
      unique case (r_state)
        // GAP has already served its dead cycle, so it leaves through the same decision as IDLE.
        S_IDLE, S_GAP: begin
          r_grant    <= '0;
          r_vga_plot <= 1'b0;
          r_state    <= S_IDLE;
          if (r_clear_pending || i_clear_req) begin
            r_state         <= S_CLEAR;
            r_clear_pending <= 1'b0;
            r_clear_busy    <= 1'b1;
            r_cx            <= '0;
            r_cy            <= '0;
            r_vga_x         <= '0;
            r_vga_y         <= '0;
            r_vga_colour    <= CLEAR_COLOUR;
            r_vga_plot      <= 1'b1;
          end else if (w_any_req) begin
            r_state <= S_OWN;
            r_owner <= w_winner;
            r_grant <= NUM_REQ'(1) << w_winner;
          end
        end
        S_OWN: begin
          if (w_own_rel || !w_own_req) begin
            r_state    <= S_GAP;
            r_grant    <= '0;
            r_vga_plot <= 1'b0;
            r_rr       <= (r_owner == OWNER_LAST) ? '0 : r_owner + 1'b1;
          end else begin
            r_vga_x      <= w_own_x;
            r_vga_y      <= w_own_y;
            r_vga_colour <= w_own_colour;
            r_vga_plot   <= w_own_plot;
          end
        end
        S_CLEAR: begin
          if ((r_cx == X_LAST) && (r_cy == Y_LAST)) begin
            r_state      <= S_GAP;
            r_clear_busy <= 1'b0;
            r_vga_plot   <= 1'b0;
            r_cx         <= '0;
            r_cy         <= '0;
          end else if (r_cx == X_LAST) begin
            r_cx    <= '0;
            r_cy    <= r_cy + 7'd1;
            r_vga_x <= '0;
            r_vga_y <= r_cy + 7'd1;
          end else begin
            r_cx    <= r_cx + 8'd1;
            r_vga_x <= r_cx + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant      = r_grant;
  assign o_clear_busy = r_clear_busy;
  assign o_vga_x      = r_vga_x;
  assign o_vga_y      = r_vga_y;
  assign o_vga_colour = r_vga_colour;
  assign o_vga_plot   = r_vga_plot;

endmodule

// File: doc/vga_draw_arbiter.md
# vga_draw_arbiter

Shares the single pixel-write port of the 160x120, 3-bit-colour VGA adapter between several UI instruction drawers (arrow, text and shape units). Each drawer requests the port, holds it for a complete shape burst and then releases it. The arbiter also contains a built-in full-screen clear engine, so a new instruction always starts on a blank frame. It sits between the drawer units and the adapter's x/y/colour/plot inputs.

## Interface
- NUM_REQ, 4: number of drawer requesters (2..8).
- CLEAR_COLOUR, 3'b000: colour written by the clear engine.
- X_MAX, 159: last column swept by the clear engine.
- Y_MAX, 119: last row swept by the clear engine.

- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  reset, synchronous, active-low; clock clk.
- req  in  NUM_REQ  per-drawer port request, level.
- release  in  NUM_REQ  per-drawer end-of-burst pulse; only the owner's bit is honoured.
- req_x  in  8*NUM_REQ  packed x, drawer i at [8i+7:8i].
- req_y  in  7*NUM_REQ  packed y, drawer i at [7i+6:7i].
- req_colour  in  3*NUM_REQ  packed colour.
- req_plot  in  NUM_REQ  per-drawer pixel-write strobe.
- clear_req  in  1  request a full-screen clear, pulse or level.
- grant  out  NUM_REQ  one-hot owner indication; all zero when no drawer owns the port.
- clear_busy  out  1  high while the clear engine owns the port.
- vga_x  out  8  registered pixel x to the adapter.
- vga_y  out  7  registered pixel y to the adapter.
- vga_colour  out  3  registered pixel colour to the adapter.
- vga_plot  out  1  registered write strobe to the adapter.

## Operation
- States:
  - IDLE: no owner.
  - OWN: one drawer holds the port.
  - CLEAR: the engine sweeps the screen.
  - GAP: one dead cycle after each release.
- Reset: state IDLE, grant=0, clear_busy=0, all vga_* = 0, rr pointer=0, clear_pending=0, clear counters=0.
- clear_pending:
  - Set by clear_req while in any state other than CLEAR.
  - Cleared on entry to CLEAR.
- Transitions out of IDLE, in priority order:
  - clear_pending or clear_req: go to CLEAR.
  - Otherwise, any req: go to OWN with the round-robin winner.
  - Otherwise: stay in IDLE.
- Round-robin: the search starts at the rr pointer and wraps modulo NUM_REQ. The first requester found wins. After a release, rr = owner+1, wrapping to 0 after NUM_REQ-1.
- OWN:
  - The owner's x/y/colour/plot are registered onto vga_*.
  - Non-owners are ignored entirely.
  - The owner's release pulse, or a deassertion of its req, moves the arbiter to GAP.
  - No preemption: a clear_req arriving during OWN only sets clear_pending.
- GAP: grant=0, vga_plot=0, then go to IDLE. This guarantees at least one plot-free cycle between owners.
- CLEAR:
  - Sweep order: x is the inner loop, 0..X_MAX; y is the outer loop, 0..Y_MAX.
  - One pixel per cycle with vga_plot=1 and colour CLEAR_COLOUR.
  - After pixel (X_MAX,Y_MAX), go to GAP.
  - The counters return to 0 on exit.
- Output mux: vga_plot is forced to 0 in IDLE and GAP. vga_x/vga_y/vga_colour hold their last values when not plotting.
- Width rules:
  - The x counter wraps at X_MAX, not at 255.
  - The y counter increments only on the x wrap.
  - No arithmetic on requester coordinates (passed through unchanged).

## Timing
- Arbitration: req sampled high in IDLE at edge N gives grant high after edge N+1 (one-cycle grant latency).
- Data path: a drawer's req_plot/x/y/colour in cycle k appear on vga_* after the next edge (one-cycle latency). This applies from the first cycle grant is high.
- Release: release sampled at edge N gives grant low after N+1 (GAP). The earliest next grant or clear_busy is after N+2.
- Clear:
  - clear_busy rises with the first CLEAR cycle.
  - Exactly (X_MAX+1)*(Y_MAX+1) = 19200 consecutive vga_plot cycles.
  - clear_busy falls on entry to GAP.
- Simultaneous events:
  - clear_req with req in IDLE: clear wins; the drawer is granted after CLEAR and GAP complete.
  - release with clear_req in OWN: GAP, then CLEAR.
  - clear_req during CLEAR: ignored (no second sweep).
- Reset mid-operation:
  - reset_n low at any edge aborts OWN/CLEAR.
  - All outputs return to reset values after that edge.
  - No partial pixel is emitted.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with req=4'b1111 -> grant=0, vga_plot=0, clear_busy=0 throughout; grant=4'b0001 two edges after release.
- Round-robin:
  - Stimulus: req=4'b1111 held; each owner pulses release after 5 plots.
  - Required grant order: 0001, 0010, 0100, 1000, 0001, with exactly one grant=0 cycle between owners.
- Pass-through:
  - Owner 2 drives x=79, y=63, colour=3'b010, plot=1 for 8 cycles -> vga_* match one cycle later.
  - Other drawers toggling plot -> no effect on vga_*.
- Clear:
  - Stimulus: pulse clear_req in IDLE.
  - Required: 19200 consecutive vga_plot cycles; the first pixel is (0,0) and the last is (159,119); clear_busy high for exactly 19200 cycles.
- Collision:
  - Stimulus: clear_req while owner 1 is drawing.
  - Required: owner 1 is not interrupted; after its release come 1 GAP cycle, then the clear, then 1 GAP cycle, then the next round-robin grant.
- Reset mid-clear:
  - Stimulus: assert reset_n=0 at pixel (40,10).
  - Required: vga_plot=0 after the edge; a fresh clear_req restarts the sweep at (0,0).
